// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM subordinate: word-organised storage with byte/halfword/word
// lanes, a fixed number of wait states per OKAY data phase, and a two-cycle
// ERROR response for illegal transfers.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int         IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       wcnt, wcnt_nxt;
    logic             capture;

    // Registered address-phase information for the transfer in its data phase.
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             write_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             accept;
    logic             legal;
    logic             addr_legal;
    logic [IDX_W-1:0] haddr_idx;
    logic [3:0]       be;

    // Burst type, protection and the SEQ/NONSEQ distinction do not affect this target.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

    assign accept    = HSEL && HREADY && HTRANS[1];
    assign haddr_idx = HADDR[IDX_W+1:2];

    // The address must land inside the array with no stray upper bits set.
    assign addr_legal = ((HADDR >> (IDX_W + 2)) == '0) && (int'(haddr_idx) < MEM_DEPTH);

    // Legality of the address phase on the bus: range, size and alignment.
    always_comb begin
        legal = addr_legal;
        case (HSIZE)
            3'd0:    ;
            3'd1:    if (HADDR[0])          legal = 1'b0;
            3'd2:    if (HADDR[1:0] != 2'b00) legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

    // Next-state logic: IDLE, DATA and ERR2 are transfer boundaries that may accept.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        state_nxt = state;
        wcnt_nxt  = wcnt;
        capture   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (wcnt == 4'd1) state_nxt = ST_DATA;
                else              wcnt_nxt  = wcnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (accept) begin
                    capture = 1'b1;
                    if (!legal) begin
                        state_nxt = ST_ERR1;
                    end else if (WS == 4'd0) begin
                        state_nxt = ST_DATA;
                    end else begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = WS;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // State, wait counter and captured address phase, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (!HRESETn) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (capture) begin
                idx_q   <= haddr_idx;
                off_q   <= HADDR[1:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
        end
    end

    // Little-endian lane enables for the transfer in its data phase.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be = 4'b0001 << off_q;
            2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Write the enabled lanes at the end of a write DATA cycle; a reset edge cancels it.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; contents survive
        // HRESETn and only the control path returns to IDLE.
        if (HRESETn && state == ST_DATA && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // A write lands at the end of its DATA cycle, so a read whose DATA cycle
    // follows immediately already sees the merged word.
    assign HRDATA    = (state == ST_DATA && !write_q) ? mem[idx_q] : '0;
    assign HREADYOUT = (state != ST_WAIT) && (state != ST_ERR1);
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule
